// File: rtl/fpga_pkg.sv
// Shared definitions for the output-channel FIFO: default geometry and program-state enum.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpga_pkg;

  // Default output-channel word width in bits.
  localparam int DEFAULT_WIDTH = 12;

  // Default number of buffered words; must be a power of two, at least 2.
  localparam int DEFAULT_DEPTH = 8;

  // Program lifecycle as seen by the output channel.
  //   RUN   : program is still producing words
  //   DRAIN : program has finished, buffered words are still leaving
  //   DONE  : program finished and every word has left; held until reset
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/out_channel_fifo_if.sv
// Output-channel handshake bundle: producer push side plus consumer valid/ready side.
// Latency: n/a (wires only).
// Backpressure: consumer stalls the channel by holding outReady low.
interface out_channel_fifo_if
  import fpga_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Producer side
  logic             push;
  logic [WIDTH-1:0] pushData;
  logic             finish;

  // Consumer side
  logic             outReady;
  logic             outValid;
  logic [WIDTH-1:0] outData;
  logic             outLast;

  // Environment driving the FIFO: program writer and downstream consumer.
  modport master (
    output push,
    output pushData,
    output finish,
    output outReady,
    input  outValid,
    input  outData,
    input  outLast
  );

  // The FIFO itself.
  modport slave (
    input  push,
    input  pushData,
    input  finish,
    input  outReady,
    output outValid,
    output outData,
    output outLast
  );

endinterface

// File: rtl/out_channel_fifo.sv
// Buffers a program's output-channel words and tracks its RUN/DRAIN/DONE lifecycle.
// Latency: a word accepted at one clock edge is on outData in the following cycle; no bypass.
// Backpressure: outReady stalls the read side; pushes while full are dropped and flagged.
module out_channel_fifo
  import fpga_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  out_channel_fifo_if.slave      ch,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            total,
  output logic                   overflow,
  output logic                   lateWrite,
  output logic                   done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [15:0]   TOTAL_MAX  = 16'hFFFF;

  state_t           state;
  state_t           state_next;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             drop;
  logic             late;
  logic             pop;
  logic [CW-1:0]    count_next;

  // Everything visible downstream comes straight from registered state,
  // so a word written this cycle only shows up after the next edge.
  assign ch.outValid = (count != '0);
  assign ch.outData  = mem[rd_ptr];
  assign ch.outLast  = ch.outValid && (state == DRAIN) && (count == CW'(1));
  assign full        = (count == COUNT_FULL);
  assign done        = (state == DONE);

  // Classify this cycle's push and pop, and work out the occupancy after the edge.
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  always_comb begin
    accept     = ch.push && (state == RUN) && !full;
    drop       = ch.push && (state == RUN) && full;
    late       = ch.push && (state != RUN);
    pop        = ch.outValid && ch.outReady;
    count_next = count;
    case ({accept, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Lifecycle: finish moves RUN to DRAIN (a push in that same cycle is still taken);
  // DRAIN ends at the edge that leaves the buffer empty, or at once if already empty.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (ch.finish) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (count_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Lifecycle state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Pointers, occupancy, accepted-word total and sticky error flags.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      total     <= '0;
      overflow  <= 1'b0;
      lateWrite <= 1'b0;
    end else begin
      count <= count_next;
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (total != TOTAL_MAX) begin
          total <= total + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (late) begin
        lateWrite <= 1'b1;
      end
    end
  end

  // Word storage; contents are meaningless until written, so no reset here.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr] <= ch.pushData;
    end
  end

endmodule

// File: doc/out_channel_fifo.md
OUT_CHANNEL_FIFO -- requirements
Module: out_channel_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 12, meaning the output-channel word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the buffered word count; it SHALL be a power of two, at least 2.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on posedge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port push, input, 1: the program writes an out-channel word this cycle.
REQ-006 SHALL have port pushData, input, WIDTH: the word being written.
REQ-007 SHALL have port finish, input, 1: the program has finished; level or pulse.
REQ-008 SHALL have port outReady, input, 1: the downstream consumer accepts outData this cycle.
REQ-009 SHALL have port outValid, output, 1: outData holds a buffered word.
REQ-010 SHALL have port outData, output, WIDTH: the oldest buffered word.
REQ-011 SHALL have port outLast, output, 1: outData is the final word of the program.
REQ-012 SHALL have port full, output, 1: count equals DEPTH.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1: the number of buffered words.
REQ-014 SHALL have port total, output, 16: words accepted since reset; saturates at 65535.
REQ-015 SHALL have port overflow, output, 1: sticky flag; a push was dropped.
REQ-016 SHALL have port lateWrite, output, 1: sticky flag; a push arrived after finish.
REQ-017 SHALL have port done, output, 1: the program has finished and every word has drained.

Function
REQ-018 SHALL store words in an internal DEPTH-entry array with write and read pointers that wrap modulo DEPTH.
REQ-019 SHALL drive outValid = (count != 0) and outData = array[rdPtr] from registers.
- A word accepted in cycle N SHALL be visible on outData in cycle N+1.
REQ-020 SHALL treat a pop as outValid && outReady; rdPtr advances and count decrements at that clock edge.
REQ-021 SHALL accept a push iff state is RUN and full is low.
- On accept: write pushData, advance wrPtr, increment total.
REQ-022 SHALL drop a push while full, even if a pop occurs in the same cycle, and set overflow.
REQ-023 SHALL, on a simultaneous accepted push and pop, leave count unchanged and advance both pointers.
REQ-024 SHALL, on a push while empty, raise outValid in the next cycle; no bypass within the same cycle.
REQ-025 SHALL implement an FSM with states RUN, DRAIN and DONE:
- RUN->DRAIN when finish is high.
- DRAIN->DONE when count==0, including when the FIFO is already empty on entry.
- DONE is held until reset.
REQ-026 SHALL, when push and finish are high in the same RUN cycle, accept the push, then enter DRAIN.
REQ-027 SHALL, in DRAIN or DONE, ignore push, set lateWrite, and leave total unchanged.
REQ-028 SHALL drive outLast = outValid && state==DRAIN && count==1.
REQ-029 SHALL drive done high exactly when state==DONE.
REQ-030 SHALL never change count, total, or the pointers on a pop while empty, since such a pop cannot occur.

Reset
REQ-031 SHALL, on reset asserted, immediately set:
- state=RUN; pointers, count and total = 0.
- outValid, outLast, full, overflow, lateWrite, done = 0.
REQ-032 SHALL leave array contents undefined after reset; outData is don't-care while outValid is low.
REQ-033 SHALL, if reset is asserted mid-drain, discard all buffered words and return to RUN.

Structure
REQ-034 SHALL take the WIDTH/DEPTH defaults and the state enum (RUN, DRAIN, DONE) from the shared package fpga_pkg.
REQ-035 SHALL be one module with no sub-modules; the array is inferred as registers.

Verification
REQ-036 SHALL cover basic flow: push 3, then 2, with outReady=1 -> outData is 3 then 2 on successive cycles; total=2.
REQ-037 SHALL cover fill/overflow: outReady=0, push 9 words 1..9 -> full=1 after the 8th; overflow=1; words 1..8 are later read in order.
REQ-038 SHALL cover push+pop while full: count=8 with push and pop in the same cycle -> count=7; overflow=1; the pushed word is absent.
REQ-039 SHALL cover drain: push 5, then finish with outReady=0 -> state DRAIN with outLast=1; outReady=1 -> pop 5; done=1 next cycle.
REQ-040 SHALL cover late write: after done, push 7 -> lateWrite=1; count=0; total unchanged.
REQ-041 SHALL cover reset mid-drain: 4 words buffered in DRAIN, then reset pulse -> count=0, outValid=0, state RUN.
